afpm_operand_streamer: RTL and testbench
========================================

// Module: afpm_operand_streamer
// PURPOSE
// - Host-side initiator for the byte-serial logarithmic FP multiplier (AFPM) tile.
// - Accepts 16-bit operands A/B on a valid/ready port and drives them onto the tile's two 8-bit input lanes, low byte first, one byte per cycle.
// - Waits a fixed latency, then captures the result bytes from the tile's 8-bit output lane.
// - Presents the assembled result on a valid/ready port.
// PARAMETERS
// - N_BEATS      2  operand beats per transaction; operand width = 8*N_BEATS
// - RESULT_LAT   3  clock edges from the end of the final operand beat to the first result capture; legal range >= 1
// - RESULT_BEATS 2  result bytes captured; result width = 8*RESULT_BEATS
// PORTS
// - clk       in   1   clock; all state updates on the rising edge
// - rst       in   1   asynchronous, active-high reset
// - ena       in   1   advance enable; 0 freezes FSM, counters, lanes and captures
// - op_valid  in   1   operand pair valid
// - op_ready  out  1   high only in IDLE
// - op_a      in   8*N_BEATS       operand A, drives ui lane
// - op_b      in   8*N_BEATS       operand B, drives uio lane
// - ui_lane   out  8   byte to tile ui_in
// - uio_lane  out  8   byte to tile uio_in
// - uo_lane   in   8   byte from tile uo_out
// - res_valid out  1   result valid; held until accepted
// - res_ready in   1   result accept
// - res_data  out  8*RESULT_BEATS  assembled result, byte 0 = first byte captured
// - busy      out  1   high in every state other than IDLE
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; ui_lane=uio_lane=0; res_data=0; res_valid=0; busy=0; op_ready=1.
// - States: IDLE -> SEND -> WAIT -> CAPT -> HOLD -> IDLE.
// - IDLE: op_ready=1. At edge E_A where op_valid & ena:
//   - latch op_a/op_b;
//   - registered lanes take byte 0 (ui_lane=op_a[7:0], uio_lane=op_b[7:0]);
//   - move to SEND, beat_cnt=0.
// - SEND: beat i (bits 8i+7:8i) is on the lanes for one enabled cycle. Beat i+1 loads at each enabled edge.
//   - The edge ending beat N_BEATS-1 is E_L = E_A+N_BEATS (with ena held high).
//   - At E_L: both lanes return to 8'h00; move to WAIT.
// - WAIT: counts RESULT_LAT-1 enabled edges, then enters CAPT.
// - CAPT: uo_lane is sampled at edges E_L+RESULT_LAT+j, j=0..RESULT_BEATS-1, into res_data[8j+:8].
//   - At the final capture edge, res_valid<=1 and the FSM moves to HOLD.
// - Latency with ena held high: res_valid rises at E_A+N_BEATS+RESULT_LAT+RESULT_BEATS-1 (defaults: E_A+6).
// - HOLD: res_valid and res_data stay stable until res_valid & res_ready.
//   - At that edge: res_valid<=0, return to IDLE.
//   - res_data keeps its last value until the next capture.
// - ena=0 in any state: no state, counter, lane or capture change. Handshake edges are ignored; res_valid is held.
// - op_valid outside IDLE is ignored; no queueing.
// - res_ready with res_valid=0 has no effect.
// - A HOLD handshake and op_valid in the same cycle: the op is accepted on the following edge at the earliest (one IDLE cycle).
// - Operand latches are not modified after E_A, even if op_a/op_b change.
// - rst mid-transaction aborts it. No partial result is ever flagged valid.
// - Counters are sized $clog2 of their max count + 1. No wrap occurs inside a transaction.
// CONFIGURATION
// - AFPM_STREAMER_TXN_CNT_EN defined:
//   - adds output txn_count (16 bits), reset to 0;
//   - increments on each result handshake (res_valid & res_ready & ena);
//   - wraps 16'hFFFF -> 16'h0000.
// - AFPM_STREAMER_TXN_CNT_EN undefined: txn_count port and counter logic are absent; all other behaviour is identical.
// TESTING
// - Reset: assert rst while in SEND with lanes=8'h3E -> lanes=8'h00, res_valid=0, busy=0 immediately; op_ready=1 after release.
// - Basic: A=16'h3E00, B=16'h4200 -> ui_lane 00 then 3E, uio_lane 00 then 42.
//   - Mock tile drives uo_lane 8'h80 then 8'h44 at the capture edges -> res_data=16'h4480, res_valid rises at E_A+6.
// - Backpressure: hold res_ready=0 for 5 cycles -> res_valid=1 and res_data=16'h4480 stable, op_ready=0.
//   - op_valid pulsed during HOLD is not accepted.
// - Stall: ena=0 for 3 cycles during beat 0 -> beat 0 lasts 4 cycles, res_valid rises at E_A+9, result unchanged.
// - Back-to-back: 2 transactions with res_ready tied 1 and op_valid tied 1 -> second accepted 1 cycle after the first handshake; both results correct.
// - With AFPM_STREAMER_TXN_CNT_EN: after the back-to-back test txn_count=2; reset returns it to 0.

Source files
------------

// File: rtl/afpm_operand_streamer_if.sv
// Handshake and byte-lane bundle between a host and the AFPM operand streamer.
// master: the streamer side (drives lanes, result and status).
// slave:  the host/tile side (drives operands, enable, result accept and uo lane).
interface afpm_operand_streamer_if #(
    parameter int N_BEATS      = 2,
    parameter int RESULT_BEATS = 2
);
    logic                      ena;
    logic                      op_valid;
    logic                      op_ready;
    logic [8*N_BEATS-1:0]      op_a;
    logic [8*N_BEATS-1:0]      op_b;
    logic [7:0]                ui_lane;
    logic [7:0]                uio_lane;
    logic [7:0]                uo_lane;
    logic                      res_valid;
    logic                      res_ready;
    logic [8*RESULT_BEATS-1:0] res_data;
    logic                      busy;

    modport master (
        input  ena, op_valid, op_a, op_b, uo_lane, res_ready,
        output op_ready, ui_lane, uio_lane, res_valid, res_data, busy
    );

    modport slave (
        output ena, op_valid, op_a, op_b, uo_lane, res_ready,
        input  op_ready, ui_lane, uio_lane, res_valid, res_data, busy
    );
endinterface

// File: rtl/afpm_operand_streamer.sv
// AFPM operand streamer: takes a 16-bit operand pair, serialises it low byte
// first onto the tile's ui/uio lanes, waits the tile latency, captures the
// result bytes from the uo lane and offers the assembled result to the host.
// Optional feature macro: AFPM_STREAMER_TXN_CNT_EN adds a 16-bit wrapping
// count of completed result handshakes on output txn_count.
module afpm_operand_streamer #(
    parameter int N_BEATS      = 2,
    parameter int RESULT_LAT   = 3,
    parameter int RESULT_BEATS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    afpm_operand_streamer_if.master    bus
`ifdef AFPM_STREAMER_TXN_CNT_EN
    ,
    output logic [15:0]                txn_count
`endif
);
    localparam int OP_W     = 8 * N_BEATS;
    localparam int RES_W    = 8 * RESULT_BEATS;
    localparam int BEAT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int CAP_W    = (RESULT_BEATS > 1) ? $clog2(RESULT_BEATS) : 1;
    // WAIT spends RESULT_LAT-1 enabled edges; the counter runs 0..WAIT_MAX.
    localparam int WAIT_MAX = (RESULT_LAT > 2) ? RESULT_LAT - 2 : 0;
    localparam int WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_CAPT,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CAP_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic [OP_W-1:0]    op_a_q, op_a_d;
    logic [OP_W-1:0]    op_b_q, op_b_d;
    logic [7:0]         ui_lane_q, ui_lane_d;
    logic [7:0]         uio_lane_q, uio_lane_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic               op_ready_q, op_ready_d;
`ifdef AFPM_STREAMER_TXN_CNT_EN
    logic [15:0]        txn_cnt_q, txn_cnt_d;
`endif

    // Next-state logic: everything holds unless ena is high.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ui_lane_d   = ui_lane_q;
        uio_lane_d  = uio_lane_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
`ifdef AFPM_STREAMER_TXN_CNT_EN
        txn_cnt_d   = txn_cnt_q;
`endif
        if (bus.ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_a_d     = bus.op_a;
                        op_b_d     = bus.op_b;
                        ui_lane_d  = bus.op_a[7:0];
                        uio_lane_d = bus.op_b[7:0];
                        beat_cnt_d = '0;
                        state_d    = S_SEND;
                    end
                end
                S_SEND: begin
                    if (beat_cnt_q == BEAT_W'(N_BEATS - 1)) begin
                        // Last beat done: park the lanes at zero while the tile computes.
                        ui_lane_d  = 8'h00;
                        uio_lane_d = 8'h00;
                        wait_cnt_d = '0;
                        cap_cnt_d  = '0;
                        state_d    = (RESULT_LAT == 1) ? S_CAPT : S_WAIT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        ui_lane_d  = 8'(op_a_q >> (8 * (int'(beat_cnt_q) + 1)));
                        uio_lane_d = 8'(op_b_q >> (8 * (int'(beat_cnt_q) + 1)));
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_W'(WAIT_MAX)) begin
                        state_d = S_CAPT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                S_CAPT: begin
                    res_data_d = (res_data_q & ~(RES_W'(8'hFF) << (8 * int'(cap_cnt_q))))
                               | (RES_W'(bus.uo_lane) << (8 * int'(cap_cnt_q)));
                    if (cap_cnt_q == CAP_W'(RESULT_BEATS - 1)) begin
                        res_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        cap_cnt_d = cap_cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = S_IDLE;
`ifdef AFPM_STREAMER_TXN_CNT_EN
                        txn_cnt_d   = txn_cnt_q + 16'd1;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Status flags are registered from the next state so they track it exactly.
        busy_d     = (state_d != S_IDLE);
        op_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            cap_cnt_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ui_lane_q   <= 8'h00;
            uio_lane_q  <= 8'h00;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b1;
`ifdef AFPM_STREAMER_TXN_CNT_EN
            txn_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ui_lane_q   <= ui_lane_d;
            uio_lane_q  <= uio_lane_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            op_ready_q  <= op_ready_d;
`ifdef AFPM_STREAMER_TXN_CNT_EN
            txn_cnt_q   <= txn_cnt_d;
`endif
        end
    end

    assign bus.op_ready  = op_ready_q;
    assign bus.ui_lane   = ui_lane_q;
    assign bus.uio_lane  = uio_lane_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = busy_q;
`ifdef AFPM_STREAMER_TXN_CNT_EN
    assign txn_count     = txn_cnt_q;
`endif
endmodule

// File: tb/tb_afpm_operand_streamer.sv
// Self-checking bench for afpm_operand_streamer. The reference model tracks
// the transaction as a count of enabled edges since acceptance and derives
// the expected lanes, capture points and result from that count.
module tb_afpm_operand_streamer;
    localparam int N_BEATS      = 2;
    localparam int RESULT_LAT   = 3;
    localparam int RESULT_BEATS = 2;
    localparam int LAST_K       = N_BEATS + RESULT_LAT + RESULT_BEATS - 1;
    localparam int FIRST_CAP    = N_BEATS + RESULT_LAT;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;

    afpm_operand_streamer_if #(.N_BEATS(N_BEATS), .RESULT_BEATS(RESULT_BEATS)) bus ();

`ifdef AFPM_STREAMER_TXN_CNT_EN
    logic [15:0] txn_count;
`endif

    afpm_operand_streamer #(
        .N_BEATS     (N_BEATS),
        .RESULT_LAT  (RESULT_LAT),
        .RESULT_BEATS(RESULT_BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef AFPM_STREAMER_TXN_CNT_EN
        ,
        .txn_count(txn_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. stall: cycles with ena low right after acceptance;
    // rand_ena: random ena afterwards; hold: cycles of res_ready low in HOLD;
    // b2b: op_valid and res_ready tied high; exp_lat: expected cycles to res_valid (-1 skips).
    task automatic txn(input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] r0, input logic [7:0] r1,
                       input int stall, input bit rand_ena, input int hold,
                       input bit b2b, input int exp_lat);
        int k;
        int cyc;
        logic [7:0]  rb [RESULT_BEATS];
        logic [15:0] exp_res;
        logic [7:0]  exp_ui, exp_uio;
        rb[0]   = r0;
        rb[1]   = r1;
        exp_res = {r1, r0};
        chk("idle_op_ready", 32'(bus.op_ready), 32'd1);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_valid  = 1'b1;
        bus.ena       = 1'b1;
        bus.res_ready = b2b;
        bus.uo_lane   = 8'($urandom);
        step();
        if (!b2b) bus.op_valid = 1'b0;
        bus.op_a = 16'($urandom);
        bus.op_b = 16'($urandom);
        k   = 0;
        cyc = 0;
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_op_ready", 32'(bus.op_ready), 32'd0);
        chk("beat0_ui", 32'(bus.ui_lane), 32'(a[7:0]));
        chk("beat0_uio", 32'(bus.uio_lane), 32'(b[7:0]));
        while (k < LAST_K && cyc < 200) begin
            if (cyc < stall) bus.ena = 1'b0;
            else if (rand_ena) bus.ena = ($urandom_range(0, 3) != 0);
            else bus.ena = 1'b1;
            if (bus.ena && (k + 1) >= FIRST_CAP) bus.uo_lane = rb[k + 1 - FIRST_CAP];
            else bus.uo_lane = 8'($urandom);
            step();
            cyc++;
            if (bus.ena) k++;
            if (k < N_BEATS) begin
                exp_ui  = 8'(a >> (8 * k));
                exp_uio = 8'(b >> (8 * k));
            end else begin
                exp_ui  = 8'h00;
                exp_uio = 8'h00;
            end
            chk("lane_ui", 32'(bus.ui_lane), 32'(exp_ui));
            chk("lane_uio", 32'(bus.uio_lane), 32'(exp_uio));
            chk("res_valid_timing", 32'(bus.res_valid), 32'(k == LAST_K));
            chk("busy_in_txn", 32'(bus.busy), 32'd1);
        end
        chk("txn_completes", 32'(k), 32'(LAST_K));
        if (exp_lat >= 0) chk("latency", 32'(cyc), 32'(exp_lat));
        chk("res_data", 32'(bus.res_data), 32'(exp_res));
        bus.ena = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.op_valid = (h == 2);
            bus.op_a     = 16'($urandom);
            step();
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_data", 32'(bus.res_data), 32'(exp_res));
            chk("hold_op_ready", 32'(bus.op_ready), 32'd0);
        end
        if (!b2b) bus.op_valid = 1'b0;
        if (rand_ena) begin
            bus.ena       = 1'b0;
            bus.res_ready = 1'b1;
            step();
            chk("hs_ignored_no_ena", 32'(bus.res_valid), 32'd1);
            bus.ena = 1'b1;
        end
        bus.res_ready = 1'b1;
        step();
        hs_cnt++;
        chk("hs_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("hs_op_ready", 32'(bus.op_ready), 32'd1);
        chk("hs_busy", 32'(bus.busy), 32'd0);
        chk("hs_data_kept", 32'(bus.res_data), 32'(exp_res));
`ifdef AFPM_STREAMER_TXN_CNT_EN
        chk("txn_count", 32'(txn_count), 32'(hs_cnt[15:0]));
`endif
        bus.res_ready = b2b;
    endtask

    initial begin
        rst           = 1'b1;
        bus.ena       = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.uo_lane   = '0;
        bus.res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ui", 32'(bus.ui_lane), 32'd0);
        chk("rst_uio", 32'(bus.uio_lane), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op_ready", 32'(bus.op_ready), 32'd1);

        // Reset in the middle of SEND while beat 1 (3E/42) is on the lanes.
        bus.ena      = 1'b1;
        bus.op_a     = 16'h3E00;
        bus.op_b     = 16'h4200;
        bus.op_valid = 1'b1;
        step();
        bus.op_valid = 1'b0;
        step();
        chk("mid_ui_3e", 32'(bus.ui_lane), 32'h3E);
        chk("mid_uio_42", 32'(bus.uio_lane), 32'h42);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ui", 32'(bus.ui_lane), 32'd0);
        chk("async_rst_uio", 32'(bus.uio_lane), 32'd0);
        chk("async_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("post_rst_valid", 32'(bus.res_valid), 32'd0);

        // Back-to-back with op_valid and res_ready tied high.
        txn(16'h3C00, 16'h4000, 8'($urandom), 8'($urandom), 0, 1'b0, 0, 1'b1, LAST_K);
        txn(16'hC500, 16'h3A66, 8'($urandom), 8'($urandom), 0, 1'b0, 0, 1'b1, LAST_K);
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b0;
`ifdef AFPM_STREAMER_TXN_CNT_EN
        chk("txn_count_after_b2b", 32'(txn_count), 32'd2);
`endif

        // Basic transfer with 5 cycles of backpressure.
        txn(16'h3E00, 16'h4200, 8'h80, 8'h44, 0, 1'b0, 5, 1'b0, 6);
        // Stall: ena low for 3 cycles during beat 0.
        txn(16'h3E00, 16'h4200, 8'h80, 8'h44, 3, 1'b0, 0, 1'b0, 9);

        // Randomised transactions with random enable gaps.
        for (int i = 0; i < 8; i++) begin
            txn(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 2), 1'b1, $urandom_range(0, 3), 1'b0, -1);
        end

        rst = 1'b1;
        #1;
        chk("final_rst_busy", 32'(bus.busy), 32'd0);
`ifdef AFPM_STREAMER_TXN_CNT_EN
        chk("final_rst_txn_count", 32'(txn_count), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
